gpio_seq_ctrl: RTL and testbench

//  Autonomous sequencer that owns the gpio peripheral's 8-bit register bus (AD/DI/DO/rw/cs).

---
 rtl/gpio_seq_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_gpio_seq_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_seq_ctrl.sv
// gpio_seq_ctrl
// Autonomous step sequencer that owns the gpio register bus. The host loads
// WRITE / DELAY / POLL / END steps through an 8-bit cs/rw register port, then
// starts the sequence. Steps replay at a fixed one-state-per-clock cadence, so
// bit-bang timing is exact. irq (when enabled) flags completion.
module gpio_seq_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  output logic [2:0] g_ad,
  output logic [7:0] g_di,
  input  logic [7:0] g_do,
  output logic       g_rw,
  output logic       g_cs
);

  localparam logic [2:0] A_CTRL = 3'd0;
  localparam logic [2:0] A_PTR  = 3'd1;
  localparam logic [2:0] A_LEN  = 3'd2;
  localparam logic [2:0] A_STEP = 3'd3;
  localparam logic [2:0] A_CFG  = 3'd4;
  localparam logic [2:0] A_DATA = 3'd5;
  localparam logic [2:0] A_WAIT = 3'd6;
  localparam logic [2:0] A_ACK  = 3'd7;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  localparam logic [7:0]    DEPTH_B  = DEPTH[7:0];
  localparam logic [AW:0]   DEPTH_L  = DEPTH[AW:0];
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] STEP_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WR, S_DLY, S_RD, S_CHK, S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] ad;
    logic [7:0] data;
    logic [7:0] wcnt;
  } slot_t;

  // Host-side configuration
  logic [AW-1:0] ptr_q;
  logic [AW:0]   len_q;
  logic          loop_q, ien_q;
  logic [1:0]    cfg_op_q;
  logic [2:0]    cfg_ad_q;
  logic [7:0]    dat_q;

  // Sequencer state
  state_t        state_q;
  logic [AW-1:0] step_q;
  logic          done_q, err_q, abort_q;
  logic [7:0]    cur_data_q, cur_wcnt_q;
  logic [7:0]    cnt_q, att_q;
  logic          g_cs_q, g_rw_q;
  logic [2:0]    g_ad_q;
  logic [7:0]    g_di_q;
  logic          irq_q;
  logic [7:0]    do_q;

  slot_t mem_q [DEPTH];
  slot_t slot_rd;

  logic          busy, wr_en, rd_en;
  logic          start_cmd, stop_cmd, ack_cmd, cfg_wr;
  logic          last_step;
  state_t        adv_state;
  logic [AW-1:0] adv_step;

  assign busy      = (state_q != S_IDLE);
  assign wr_en     = cs & ~rw;
  assign rd_en     = cs & rw;
  assign start_cmd = wr_en & (AD == A_CTRL) & DI[0] & ~DI[1];
  assign stop_cmd  = wr_en & (AD == A_CTRL) & DI[1];
  assign ack_cmd   = wr_en & (AD == A_ACK);
  assign cfg_wr    = wr_en & ~busy;
  assign slot_rd   = mem_q[step_q];
  assign last_step = ({1'b0, step_q} == (len_q - LEN_ONE));

  // Where the sequence goes once the current step has finished
  always_comb begin
    adv_step  = step_q + STEP_ONE;
    adv_state = S_FETCH;
    if (last_step) begin
      if (loop_q) begin
        adv_step = '0;
      end else begin
        adv_step  = step_q;
        adv_state = S_DONE;
      end
    end
  end

  // Host register writes; sequence-shaping registers are frozen while busy
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      ien_q    <= 1'b0;
      cfg_op_q <= '0;
      cfg_ad_q <= '0;
      dat_q    <= '0;
    end else if (wr_en) begin
      if (AD == A_CTRL) begin
        loop_q <= DI[2];
        ien_q  <= DI[3];
      end else if (cfg_wr) begin
        case (AD)
          A_PTR:  ptr_q <= DI[AW-1:0];
          A_LEN:  len_q <= (DI > DEPTH_B) ? DEPTH_L : DI[AW:0];
          A_CFG:  begin
            cfg_op_q <= DI[7:6];
            cfg_ad_q <= DI[2:0];
          end
          A_DATA: dat_q <= DI;
          A_WAIT: ptr_q <= ptr_q + STEP_ONE;
          default: ;
        endcase
      end
    end
  end

  // Step memory: a WAIT write commits the staged slot at PTR
  always_ff @(posedge clk) begin
    if (!rst && cfg_wr && (AD == A_WAIT)) begin
      mem_q[ptr_q] <= {cfg_op_q, cfg_ad_q, dat_q, DI};
    end
  end

  // Sequencer FSM with registered gpio strobes; STOP overrides every state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      g_cs_q  <= 1'b0;
      g_rw_q  <= 1'b1;
      g_ad_q  <= '0;
      g_di_q  <= '0;
    end else begin
      g_cs_q <= 1'b0;
      g_rw_q <= 1'b1;
      if (ack_cmd) begin
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        abort_q <= 1'b0;
      end
      if (stop_cmd) begin
        state_q <= S_IDLE;
        abort_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_cmd && (len_q != '0)) begin
              state_q <= S_FETCH;
              step_q  <= '0;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
              abort_q <= 1'b0;
            end
          end
          S_FETCH: begin
            cur_data_q <= slot_rd.data;
            cur_wcnt_q <= slot_rd.wcnt;
            case (slot_rd.op)
              OP_WRITE: begin
                state_q <= S_WR;
                g_cs_q  <= 1'b1;
                g_rw_q  <= 1'b0;
                g_ad_q  <= slot_rd.ad;
                g_di_q  <= slot_rd.data;
              end
              OP_DELAY: begin
                if (slot_rd.wcnt == 8'd0) begin
                  state_q <= adv_state;
                  step_q  <= adv_step;
                end else begin
                  state_q <= S_DLY;
                  cnt_q   <= slot_rd.wcnt;
                end
              end
              OP_POLL: begin
                state_q <= S_RD;
                g_cs_q  <= 1'b1;
                g_ad_q  <= slot_rd.ad;
                att_q   <= 8'd0;
              end
              default: state_q <= S_DONE;
            endcase
          end
          S_WR: begin
            if (cur_wcnt_q != 8'd0) begin
              state_q <= S_DLY;
              cnt_q   <= cur_wcnt_q;
            end else begin
              state_q <= adv_state;
              step_q  <= adv_step;
            end
          end
          S_DLY: begin
            if (cnt_q == 8'd1) begin
              state_q <= adv_state;
              step_q  <= adv_step;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_RD: begin
            state_q <= S_CHK;
            att_q   <= att_q + 8'd1;
          end
          S_CHK: begin
            if ((g_do & cur_data_q) == cur_data_q) begin
              state_q <= adv_state;
              step_q  <= adv_step;
            end else if ((cur_wcnt_q != 8'd0) && (att_q == cur_wcnt_q)) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RD;
              g_cs_q  <= 1'b1;
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Level interrupt follows done one cycle later when enabled
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= done_q & ien_q;
  end

  // Host read-back register
  always_ff @(posedge clk) begin
    if (rst) begin
      do_q <= 8'h00;
    end else if (rd_en) begin
      case (AD)
        A_CTRL:  do_q <= {4'b0, abort_q, err_q, done_q, busy};
        A_PTR:   do_q <= {{(8-AW){1'b0}}, ptr_q};
        A_LEN:   do_q <= {{(7-AW){1'b0}}, len_q};
        A_STEP:  do_q <= {{(8-AW){1'b0}}, step_q};
        default: do_q <= 8'h00;
      endcase
    end
  end

  assign DO   = do_q;
  assign irq  = irq_q;
  assign g_cs = g_cs_q;
  assign g_rw = g_rw_q;
  assign g_ad = g_ad_q;
  assign g_di = g_di_q;

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// tb_gpio_seq_ctrl
// Randomized scoreboard bench: each started program is expanded by a timing
// model into expected gpio strobes (cycle, rw, ad, di); a monitor pops them as
// the DUT strobes and also checks host read-back values.
module tb_gpio_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] AD  = 3'd0;
  logic [7:0] DI  = 8'h00;
  logic       rw  = 1'b1;
  logic       cs  = 1'b0;
  logic [7:0] g_do = 8'h00;
  logic [7:0] DO;
  logic       irq;
  logic [2:0] g_ad;
  logic [7:0] g_di;
  logic       g_rw;
  logic       g_cs;

  gpio_seq_ctrl #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .irq(irq), .g_ad(g_ad), .g_di(g_di), .g_do(g_do), .g_rw(g_rw), .g_cs(g_cs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       rw;
    logic [2:0] ad;
    logic [7:0] di;
  } strobe_t;

  strobe_t    exp_q[$];
  logic [7:0] resp_q[$];
  logic [7:0] rdexp_q[$];
  string      rdnm_q[$];

  logic [1:0] p_op  [16];
  logic [2:0] p_ad  [16];
  logic [7:0] p_dat [16];
  logic [7:0] p_w   [16];
  int         p_fail[16];
  int         p_len;
  logic [7:0] m_di = 8'h00;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // gpio peripheral model: answers each read strobe from the response queue
  logic rd_seen = 1'b0;
  always @(posedge clk) begin
    rd_seen <= cs & rw & ~rst;
    if (g_cs && g_rw) g_do <= (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
  end

  // Monitor: host read data and gpio strobes against the scoreboard
  strobe_t mon_s;
  int      mon_e;
  string   mon_n;
  always @(negedge clk) begin
    if (rd_seen) begin
      if (rdexp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_orphan: got DO=%0h, required no read", DO);
      end else begin
        mon_e = int'(rdexp_q.pop_front());
        mon_n = rdnm_q.pop_front();
        chk(mon_n, int'(DO), mon_e);
      end
    end
    if (g_cs) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL strobe_extra: got rw=%0d ad=%0d di=%0h at cycle %0d, required no strobe",
                 g_rw, g_ad, g_di, cyc);
      end else begin
        mon_s = exp_q.pop_front();
        chk("strobe_cycle", cyc, mon_s.cyc);
        chk("strobe_bus", int'({g_rw, g_ad, g_di}), int'({mon_s.rw, mon_s.ad, mon_s.di}));
      end
    end
  end

  task automatic hw(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic hr(input logic [2:0] a, input logic [7:0] e, input string nm);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; AD = a;
    rdexp_q.push_back(e);
    rdnm_q.push_back(nm);
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cs = 1'b0; rw = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    resp_q.delete();
    m_di = 8'h00;
  endtask

  task automatic load_prog();
    hw(3'd1, 8'h00);
    for (int i = 0; i < p_len; i++) begin
      hw(3'd4, {p_op[i], 3'b000, p_ad[i]});
      hw(3'd5, p_dat[i]);
      hw(3'd6, p_w[i]);
    end
    hr(3'd1, 8'(p_len % 16), "ptr_after_load");
  endtask

  // Timing model: FETCH is visible at cycle s; WRITE strobes at s+1 then
  // spends w delay cycles; DELAY costs 1+w; POLL read k strobes at s+2k-1.
  // Returns the cycle in which the DONE state is visible.
  task automatic model_run(input int t0, output int d, output logic e, output int ls);
    int         s;
    int         nr;
    logic [7:0] v;
    strobe_t    ev;
    s = t0; e = 1'b0; ls = 0; d = -1;
    for (int i = 0; i < p_len; i++) begin
      ls = i;
      if (p_op[i] == 2'b00) begin
        ev.cyc = s + 1; ev.rw = 1'b0; ev.ad = p_ad[i]; ev.di = p_dat[i];
        exp_q.push_back(ev);
        m_di = p_dat[i];
        s = s + 2 + int'(p_w[i]);
      end else if (p_op[i] == 2'b01) begin
        s = s + 1 + int'(p_w[i]);
      end else if (p_op[i] == 2'b10) begin
        if ((p_w[i] != 8'd0) && (p_fail[i] >= int'(p_w[i]))) begin
          nr = int'(p_w[i]);
          e  = 1'b1;
        end else begin
          nr = p_fail[i] + 1;
        end
        for (int k = 1; k <= nr; k++) begin
          ev.cyc = s + 2 * k - 1; ev.rw = 1'b1; ev.ad = p_ad[i]; ev.di = m_di;
          exp_q.push_back(ev);
          v = 8'($urandom);
          if (e || (k < nr)) resp_q.push_back(v & ~p_dat[i]);
          else               resp_q.push_back(v | p_dat[i]);
        end
        if (e) begin
          d = s + 2 * nr + 1;
          return;
        end
        s = s + 2 * nr + 1;
      end else begin
        d = s + 1;
        return;
      end
    end
    d = s;
  endtask

  task automatic run_prog(input string nm);
    int   t0, d, ls;
    logic e;
    load_prog();
    hw(3'd2, 8'(p_len));
    hw(3'd0, 8'h09);
    t0 = cyc;
    model_run(t0, d, e, ls);
    @(negedge clk);
    while (!irq && (cyc < d + 20)) @(negedge clk);
    if (!irq) begin
      total++; bad++;
      $display("FAIL %s_irq_timeout: irq=0 at cycle %0d, required 1 at cycle %0d", nm, cyc, d + 2);
      do_reset();
      return;
    end
    chk({nm, "_irq_cycle"}, cyc, d + 2);
    hr(3'd0, {5'b0, e, 2'b10}, {nm, "_status"});
    hr(3'd3, 8'(ls), {nm, "_step"});
    hw(3'd7, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_irq_clear"}, int'(irq), 0);
    chk({nm, "_strobes_left"}, exp_q.size(), 0);
    chk({nm, "_resp_left"}, resp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  int r;
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_g_cs", int'(g_cs), 0);
    chk("rst_g_rw", int'(g_rw), 1);
    chk("rst_irq", int'(irq), 0);
    chk("rst_do", int'(DO), 0);
    chk("rst_g_bus", int'({g_ad, g_di}), 0);
    hr(3'd0, 8'h00, "rst_ctrl");
    hr(3'd2, 8'h00, "rst_len");
    hr(3'd3, 8'h00, "rst_step");

    // two timed writes
    p_len = 2;
    p_op[0] = 2'b00; p_ad[0] = 3'd7; p_dat[0] = 8'hFF; p_w[0] = 8'd0; p_fail[0] = 0;
    p_op[1] = 2'b00; p_ad[1] = 3'd3; p_dat[1] = 8'hA5; p_w[1] = 8'd3; p_fail[1] = 0;
    run_prog("ex_write");

    // poll that matches on the third read
    p_len = 1;
    p_op[0] = 2'b10; p_ad[0] = 3'd3; p_dat[0] = 8'h01; p_w[0] = 8'd5; p_fail[0] = 2;
    run_prog("poll_ok");

    // poll that never matches and times out
    p_op[0] = 2'b10; p_ad[0] = 3'd3; p_dat[0] = 8'h80; p_w[0] = 8'd4; p_fail[0] = 4;
    run_prog("poll_err");

    // random programs
    for (int n = 0; n < 30; n++) begin
      p_len = $urandom_range(1, 6);
      for (int i = 0; i < p_len; i++) begin
        r = $urandom_range(0, 9);
        p_op[i]   = (r < 4) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        p_ad[i]   = 3'($urandom);
        p_dat[i]  = 8'($urandom_range(1, 255));
        p_w[i]    = 8'($urandom_range(0, 4));
        p_fail[i] = $urandom_range(0, 4);
      end
      run_prog("rnd");
    end

    // looping long delay aborted by STOP
    p_len = 1;
    p_op[0] = 2'b01; p_ad[0] = 3'd0; p_dat[0] = 8'h00; p_w[0] = 8'd200;
    load_prog();
    hw(3'd2, 8'd1);
    hw(3'd0, 8'h0D);
    repeat (20) @(negedge clk);
    hr(3'd0, 8'h01, "stop_busy_before");
    hw(3'd2, 8'd5);
    hw(3'd0, 8'h02);
    hr(3'd0, 8'h08, "stop_status");
    repeat (3) @(negedge clk);
    chk("stop_irq", int'(irq), 0);
    hr(3'd2, 8'd1, "len_locked");
    hw(3'd7, 8'h00);

    // STOP and START together: STOP wins
    hw(3'd0, 8'h03);
    hr(3'd0, 8'h08, "stop_start");
    hw(3'd7, 8'h00);
    hr(3'd0, 8'h00, "ack_clear");

    // pointer wrap, then START with LEN=0
    hw(3'd1, 8'd15);
    hw(3'd4, 8'h00);
    hw(3'd5, 8'h00);
    hw(3'd6, 8'h00);
    hr(3'd1, 8'h00, "ptr_wrap");
    hw(3'd2, 8'd0);
    hw(3'd0, 8'h09);
    repeat (4) @(negedge clk);
    hr(3'd0, 8'h00, "len0_start");
    chk("len0_irq", int'(irq), 0);

    // reset in the middle of a sequence
    p_len = 1;
    p_op[0] = 2'b01; p_ad[0] = 3'd0; p_dat[0] = 8'h00; p_w[0] = 8'd50;
    load_prog();
    hw(3'd2, 8'd1);
    hw(3'd0, 8'h01);
    repeat (5) @(negedge clk);
    hr(3'd0, 8'h01, "mid_busy");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_g_cs", int'(g_cs), 0);
    chk("rstmid_irq", int'(irq), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    hr(3'd0, 8'h00, "rstmid_ctrl");
    hr(3'd2, 8'h00, "rstmid_len");
    hr(3'd1, 8'h00, "rstmid_ptr");
    repeat (3) @(negedge clk);
    chk("final_rd_queue", rdexp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
